// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stage enables, flushes and PC select for traps, memory waits, branches and load-use.
// Optional stall-cycle perf counter enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        rs1_use_ID,
  input  logic        rs2_use_ID,
  input  logic [4:0]  rd_EX,
  input  logic        mem_r_EX,
  input  logic        branch_taken_EX,
  input  logic [1:0]  exp_vector_MEM,
  input  logic        mret_MEM,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        en_PC,
  output logic        en_IFID,
  output logic        en_IDEX,
  output logic        en_EXMEM,
  output logic        en_MEMWB,
  output logic        flush_IFID,
  output logic        flush_IDEX,
  output logic        flush_EXMEM,
  output logic [1:0]  pc_sel,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cycles
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_RUN        = 2'b00,
    ST_MEM_WAIT   = 2'b01,
    ST_TRAP_REDIR = 2'b10
  } state_t;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_TRAP   = 2'b10;
  localparam logic [1:0] PC_MEPC   = 2'b11;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] kind;
  logic [1:0] kind_nxt;
  logic       kind_load;

  logic trap_evt;
  logic mem_wait_evt;
  logic load_use_evt;

  assign trap_evt     = (exp_vector_MEM != 2'b00) || mret_MEM;
  assign mem_wait_evt = dmem_req && !dmem_ack;
  assign load_use_evt = mem_r_EX && (rd_EX != 5'd0) &&
                        ((rs1_use_ID && (rs1_ID == rd_EX)) ||
                         (rs2_use_ID && (rs2_ID == rd_EX)));
  // An exception outranks a simultaneous mret.
  assign kind_nxt     = (exp_vector_MEM != 2'b00) ? PC_TRAP : PC_MEPC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
      kind  <= PC_TRAP;
    end else begin
      state <= state_nxt;
      if (kind_load) begin
        kind <= kind_nxt;
      end
    end
  end

  assign ctrl_state = state;

  // Next state and combinational stage controls; flushes only ever raised with their enable.
  always_comb begin
    state_nxt   = ST_RUN;
    kind_load   = 1'b0;
    en_PC       = 1'b1;
    en_IFID     = 1'b1;
    en_IDEX     = 1'b1;
    en_EXMEM    = 1'b1;
    en_MEMWB    = 1'b1;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_EXMEM = 1'b0;
    pc_sel      = PC_SEQ;
    if (rst) begin
      en_PC    = 1'b0;
      en_IFID  = 1'b0;
      en_IDEX  = 1'b0;
      en_EXMEM = 1'b0;
      en_MEMWB = 1'b0;
    end else begin
      case (state)
        ST_MEM_WAIT: begin
          if (!dmem_ack) begin
            en_PC     = 1'b0;
            en_IFID   = 1'b0;
            en_IDEX   = 1'b0;
            en_EXMEM  = 1'b0;
            en_MEMWB  = 1'b0;
            state_nxt = ST_MEM_WAIT;
          end
        end
        ST_TRAP_REDIR: begin
          pc_sel     = kind;
          flush_IFID = 1'b1;
        end
        default: begin
          // Encoding 11 is treated as RUN and falls back to RUN.
          if (trap_evt) begin
            en_PC       = 1'b0;
            flush_IFID  = 1'b1;
            flush_IDEX  = 1'b1;
            flush_EXMEM = 1'b1;
            kind_load   = 1'b1;
            state_nxt   = ST_TRAP_REDIR;
          end else if (mem_wait_evt) begin
            en_PC     = 1'b0;
            en_IFID   = 1'b0;
            en_IDEX   = 1'b0;
            en_EXMEM  = 1'b0;
            en_MEMWB  = 1'b0;
            state_nxt = ST_MEM_WAIT;
          end else if (branch_taken_EX) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
            pc_sel     = PC_BRANCH;
          end else if (load_use_evt) begin
            en_PC      = 1'b0;
            en_IFID    = 1'b0;
            flush_IDEX = 1'b1;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!en_PC && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed, table-driven bench for pipe_hazard_ctrl with hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX;
  logic        rs1_use_ID, rs2_use_ID, mem_r_EX, branch_taken_EX;
  logic [1:0]  exp_vector_MEM;
  logic        mret_MEM, dmem_req, dmem_ack;
  logic        en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
  logic        flush_IFID, flush_IDEX, flush_EXMEM;
  logic [1:0]  pc_sel, ctrl_state;
  logic [15:0] stall_cycles;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_use_ID(rs1_use_ID), .rs2_use_ID(rs2_use_ID),
    .rd_EX(rd_EX), .mem_r_EX(mem_r_EX), .branch_taken_EX(branch_taken_EX),
    .exp_vector_MEM(exp_vector_MEM), .mret_MEM(mret_MEM),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .en_PC(en_PC), .en_IFID(en_IFID), .en_IDEX(en_IDEX), .en_EXMEM(en_EXMEM), .en_MEMWB(en_MEMWB),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .flush_EXMEM(flush_EXMEM),
    .pc_sel(pc_sel), .ctrl_state(ctrl_state), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // {en_PC,en_IFID,en_IDEX,en_EXMEM,en_MEMWB, flush_IFID,flush_IDEX,flush_EXMEM, pc_sel}
  localparam logic [9:0] O_RUN   = 10'b11111_000_00;
  localparam logic [9:0] O_LU    = 10'b00111_010_00;
  localparam logic [9:0] O_BR    = 10'b11111_110_01;
  localparam logic [9:0] O_HOLD  = 10'b00000_000_00;
  localparam logic [9:0] O_TRAP0 = 10'b01111_111_00;
  localparam logic [9:0] O_RD10  = 10'b11111_100_10;
  localparam logic [9:0] O_RD11  = 10'b11111_100_11;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, br, req, ack;
    logic [9:0] exp_o;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;

  task automatic clear_in();
    rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
    rs1_use_ID = 1'b0; rs2_use_ID = 1'b0; mem_r_EX = 1'b0; branch_taken_EX = 1'b0;
    exp_vector_MEM = 2'b00; mret_MEM = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  // Check the current cycle, then advance one clock while tracking the expected stall count.
  task automatic step(input string name, input logic [9:0] exp_o, input logic [1:0] exp_st);
    logic [9:0]  act;
    logic [15:0] exp_sc;
    #1;
    if (rst) exp_cnt = 0;
    act = {en_PC, en_IFID, en_IDEX, en_EXMEM, en_MEMWB, flush_IFID, flush_IDEX, flush_EXMEM, pc_sel};
`ifdef HAZARD_PERF_CNT_EN
    exp_sc = 16'(exp_cnt);
`else
    exp_sc = 16'd0;
`endif
    checks++;
    if (act !== exp_o) begin
      failures++;
      $display("FAIL %s outputs: got %b expected %b", name, act, exp_o);
    end
    checks++;
    if (ctrl_state !== exp_st) begin
      failures++;
      $display("FAIL %s ctrl_state: got %b expected %b", name, ctrl_state, exp_st);
    end
    checks++;
    if (stall_cycles !== exp_sc) begin
      failures++;
      $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cycles, exp_sc);
    end
    if (!rst && !exp_o[9] && exp_cnt < 65535) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"idle",        5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[1] = '{"lu_rs2",      5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[2] = '{"lu_rs1",      5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[3] = '{"match_nouse", 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[4] = '{"rd_zero",     5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[5] = '{"no_load",     5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_RUN};
    vecs[6] = '{"branch",      5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[7] = '{"branch_lu",   5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[8] = '{"req_ack",     5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN};
    vecs[9] = '{"req_ack_br",  5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, O_BR};

    clear_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    step("reset", O_HOLD, 2'b00);
    rst = 1'b0;
    step("post_reset", O_RUN, 2'b00);

    for (int i = 0; i < 10; i++) begin
      clear_in();
      rs1_ID = vecs[i].rs1; rs2_ID = vecs[i].rs2; rd_EX = vecs[i].rd;
      rs1_use_ID = vecs[i].u1; rs2_use_ID = vecs[i].u2; mem_r_EX = vecs[i].mr;
      branch_taken_EX = vecs[i].br; dmem_req = vecs[i].req; dmem_ack = vecs[i].ack;
      step(vecs[i].name, vecs[i].exp_o, 2'b00);
    end

    // Load-use bubble followed by the bubble reaching EX
    clear_in();
    mem_r_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5; rs2_use_ID = 1'b1;
    step("lu_bubble", O_LU, 2'b00);
    clear_in();
    step("lu_after", O_RUN, 2'b00);

    // Memory wait with ack low, hazards ignored while waiting
    dmem_req = 1'b1;
    step("mw_detect", O_HOLD, 2'b00);
    step("mw_wait1", O_HOLD, 2'b01);
    branch_taken_EX = 1'b1; mem_r_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5; rs2_use_ID = 1'b1;
    step("mw_wait2_ignore", O_HOLD, 2'b01);
    clear_in(); dmem_req = 1'b1;
    step("mw_wait3", O_HOLD, 2'b01);
    dmem_ack = 1'b1;
    step("mw_ack", O_RUN, 2'b01);
    clear_in();
    step("mw_done", O_RUN, 2'b00);

    // Exception trap
    exp_vector_MEM = 2'b01;
    step("exc_detect", O_TRAP0, 2'b00);
    clear_in();
    step("exc_redir", O_RD10, 2'b10);
    step("exc_done", O_RUN, 2'b00);

    // mret outranks branch and load-use
    mret_MEM = 1'b1; branch_taken_EX = 1'b1;
    mem_r_EX = 1'b1; rd_EX = 5'd9; rs1_ID = 5'd9; rs1_use_ID = 1'b1;
    step("mret_prio", O_TRAP0, 2'b00);
    clear_in();
    step("mret_redir", O_RD11, 2'b10);
    step("mret_done", O_RUN, 2'b00);

    // Exception beats mret and a pending memory wait
    exp_vector_MEM = 2'b10; mret_MEM = 1'b1; dmem_req = 1'b1;
    step("exc_mret", O_TRAP0, 2'b00);
    clear_in();
    step("exc_mret_redir", O_RD10, 2'b10);
    step("exc_mret_done", O_RUN, 2'b00);

    // Reset during MEM_WAIT
    dmem_req = 1'b1;
    step("rmw_detect", O_HOLD, 2'b00);
    step("rmw_wait", O_HOLD, 2'b01);
    rst = 1'b1;
    step("rmw_reset", O_HOLD, 2'b00);
    rst = 1'b0; clear_in();
    step("rmw_release", O_RUN, 2'b00);

    // Reset during TRAP_REDIR
    mret_MEM = 1'b1;
    step("rtr_detect", O_TRAP0, 2'b00);
    clear_in();
    rst = 1'b1;
    step("rtr_reset", O_HOLD, 2'b00);
    rst = 1'b0;
    step("rtr_release", O_RUN, 2'b00);

    // Latched kind returns to trap-vector after reset; an exception then redirects with 10
    exp_vector_MEM = 2'b11;
    step("post_rst_exc", O_TRAP0, 2'b00);
    clear_in();
    step("post_rst_redir", O_RD10, 2'b10);
    step("post_rst_done", O_RUN, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
